// File: rtl/lif_integrator.sv
// Leaky integrate-and-fire stage: saturating membrane, one-cycle addressed spike, refractory window.
// Optional spike counter output is enabled by defining LIF_SPIKE_COUNT_EN.
module lif_integrator #(
    parameter int         THRESHOLD         = 100,
    parameter int         LEAK_SHIFT        = 3,
    parameter int         REFRACTORY_CYCLES = 4,
    parameter logic [7:0] NEURON_ADDR       = 8'h01,
    parameter int         V_WIDTH           = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [31:0]               CurrentIn,
    input  logic                      CurrentValid,
    output logic                      SpikeOut,
    output logic [7:0]                AddrOut,
    output logic signed [V_WIDTH-1:0] Membrane,
    output logic                      Refractory,
    output logic [7:0]                DroppedCount
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic [15:0]               SpikeCount
`endif
);

    localparam int XW    = V_WIDTH + 2;
    localparam int C_MAX = (1 << (V_WIDTH - 1)) - 1;
    localparam int C_MIN = -C_MAX - 1;
    localparam logic signed [XW-1:0] V_MAX_X = {3'b000, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] THR_X   = XW'(THRESHOLD);
    localparam logic [7:0]           RC_INIT = 8'(REFRACTORY_CYCLES);

    typedef enum logic [0:0] {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } state_t;

    state_t                      state_r;
    logic signed [V_WIDTH-1:0]   v_r;
    logic [7:0]                  rc_r;
    logic                        spike_r;
    logic [7:0]                  addr_r;
    logic                        refract_r;
    logic [7:0]                  dropped_r;
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]                 spike_count_r;
`endif

    logic signed [V_WIDTH-1:0]   cur_sat_s;
    logic signed [V_WIDTH-1:0]   leak_s;
    logic signed [XW-1:0]        vn_s;
    logic signed [XW-1:0]        vn_clamp_s;
    logic                        fire_s;

    // Clamp a 32-bit synapse current into the membrane range.
    function automatic logic signed [V_WIDTH-1:0] sat_current(input logic signed [31:0] c);
        if (c > C_MAX) begin
            sat_current = V_WIDTH'(C_MAX);
        end else if (c < C_MIN) begin
            sat_current = V_WIDTH'(C_MIN);
        end else begin
            sat_current = c[V_WIDTH-1:0];
        end
    endfunction

    // Next membrane value: leak, integrate, then floor at zero and clamp at the positive max.
    always_comb begin
        if (CurrentValid) begin
            cur_sat_s = sat_current($signed(CurrentIn));
        end else begin
            cur_sat_s = {V_WIDTH{1'b0}};
        end
        leak_s = v_r >>> LEAK_SHIFT;
        vn_s   = {{2{v_r[V_WIDTH-1]}}, v_r}
               - {{2{leak_s[V_WIDTH-1]}}, leak_s}
               + {{2{cur_sat_s[V_WIDTH-1]}}, cur_sat_s};
        if (vn_s[XW-1]) begin
            vn_clamp_s = {XW{1'b0}};
        end else if (vn_s > V_MAX_X) begin
            vn_clamp_s = V_MAX_X;
        end else begin
            vn_clamp_s = vn_s;
        end
        fire_s = (vn_clamp_s >= THR_X);
    end

    // State machine, membrane, spike outputs and dropped-input counter.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r   <= INTEGRATE;
            v_r       <= {V_WIDTH{1'b0}};
            rc_r      <= 8'd0;
            spike_r   <= 1'b0;
            addr_r    <= 8'h00;
            refract_r <= 1'b0;
            dropped_r <= 8'd0;
`ifdef LIF_SPIKE_COUNT_EN
            spike_count_r <= 16'd0;
`endif
        end else begin
            case (state_r)
                INTEGRATE: begin
                    if (fire_s) begin
                        spike_r <= 1'b1;
                        addr_r  <= NEURON_ADDR;
                        v_r     <= {V_WIDTH{1'b0}};
`ifdef LIF_SPIKE_COUNT_EN
                        spike_count_r <= spike_count_r + 16'd1;
`endif
                        if (RC_INIT != 8'd0) begin
                            state_r   <= REFRACT;
                            rc_r      <= RC_INIT;
                            refract_r <= 1'b1;
                        end else begin
                            state_r   <= INTEGRATE;
                            rc_r      <= 8'd0;
                            refract_r <= 1'b0;
                        end
                    end else begin
                        spike_r   <= 1'b0;
                        addr_r    <= 8'h00;
                        v_r       <= vn_clamp_s[V_WIDTH-1:0];
                        refract_r <= 1'b0;
                    end
                end
                REFRACT: begin
                    spike_r <= 1'b0;
                    addr_r  <= 8'h00;
                    v_r     <= {V_WIDTH{1'b0}};
                    if (CurrentValid && (dropped_r != 8'hFF)) begin
                        dropped_r <= dropped_r + 8'd1;
                    end else begin
                        dropped_r <= dropped_r;
                    end
                    // rc of 1 (or a corrupted 0) ends the window this cycle.
                    if (rc_r <= 8'd1) begin
                        state_r   <= INTEGRATE;
                        rc_r      <= 8'd0;
                        refract_r <= 1'b0;
                    end else begin
                        state_r   <= REFRACT;
                        rc_r      <= rc_r - 8'd1;
                        refract_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= INTEGRATE;
                    v_r       <= {V_WIDTH{1'b0}};
                    rc_r      <= 8'd0;
                    spike_r   <= 1'b0;
                    addr_r    <= 8'h00;
                    refract_r <= 1'b0;
                end
            endcase
        end
    end

    assign SpikeOut     = spike_r;
    assign AddrOut      = addr_r;
    assign Membrane     = v_r;
    assign Refractory   = refract_r;
    assign DroppedCount = dropped_r;
`ifdef LIF_SPIKE_COUNT_EN
    assign SpikeCount   = spike_count_r;
`endif

endmodule

// File: tb/tb_lif_integrator.sv
// Self-checking bench for lif_integrator: behavioural model feeds an expectation queue per cycle.
module tb_lif_integrator;

    localparam int         THR  = 100;
    localparam int         LS   = 3;
    localparam int         RCY  = 4;
    localparam logic [7:0] ADDR = 8'h05;
    localparam int         VMAX = 32767;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [31:0]        CurrentIn;
    logic               CurrentValid;
    logic               SpikeOut;
    logic [7:0]         AddrOut;
    logic signed [15:0] Membrane;
    logic               Refractory;
    logic [7:0]         DroppedCount;
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]        SpikeCount;
`endif

    lif_integrator #(
        .THRESHOLD(THR), .LEAK_SHIFT(LS), .REFRACTORY_CYCLES(RCY),
        .NEURON_ADDR(ADDR), .V_WIDTH(16)
    ) dut (
        .Clk(Clk), .Reset(Reset), .CurrentIn(CurrentIn), .CurrentValid(CurrentValid),
        .SpikeOut(SpikeOut), .AddrOut(AddrOut), .Membrane(Membrane),
        .Refractory(Refractory), .DroppedCount(DroppedCount)
`ifdef LIF_SPIKE_COUNT_EN
        , .SpikeCount(SpikeCount)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        spike;
        logic [7:0]  addr;
        logic [15:0] mem;
        logic        refr;
        logic [7:0]  drop;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model state
    int m_v = 0, m_rc = 0, m_drop = 0, m_cnt = 0;
    bit m_refract_state = 0, m_spike = 0, m_refr = 0;
    logic [7:0] m_addr = 8'h00;

    function automatic obs_t sample();
        sample = {SpikeOut, AddrOut, Membrane, Refractory, DroppedCount};
    endfunction

    task automatic drive_cycle(input bit rst_n, input bit valid, input int cin);
        int i, vn;
        Reset = rst_n; CurrentValid = valid; CurrentIn = cin;
        if (!rst_n) begin
            m_v = 0; m_rc = 0; m_drop = 0; m_cnt = 0;
            m_refract_state = 0; m_spike = 0; m_refr = 0; m_addr = 8'h00;
        end else if (!m_refract_state) begin
            i = !valid ? 0 : (cin > VMAX ? VMAX : (cin < -VMAX - 1 ? -VMAX - 1 : cin));
            vn = m_v - (m_v / (1 << LS)) + i;
            if (vn < 0) vn = 0;
            if (vn > VMAX) vn = VMAX;
            if (vn >= THR) begin
                m_spike = 1; m_addr = ADDR; m_v = 0; m_cnt = (m_cnt + 1) % 65536;
                m_refract_state = 1; m_rc = RCY; m_refr = 1;
            end else begin
                m_spike = 0; m_addr = 8'h00; m_v = vn; m_refr = 0;
            end
        end else begin
            m_spike = 0; m_addr = 8'h00; m_v = 0;
            if (valid && m_drop < 255) m_drop++;
            if (m_rc == 1) begin
                m_refract_state = 0; m_refr = 0;
            end else begin
                m_refr = 1;
            end
            m_rc--;
        end
        exp_q.push_back(obs_t'{m_spike, m_addr, 16'(m_v), m_refr, 8'(m_drop)});
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 1'b1, 500);
            e = exp_q.pop_front(); g = sample();
            checks++;
            if (g !== e) $display("FAIL reset cyc%0d got=%h exp=%h", k, g, e);
            else passed++;
            checks++;
            if ({SpikeOut, AddrOut, Membrane, DroppedCount} !== 33'd0)
                $display("FAIL reset_zero cyc%0d got=%h exp=0", k, {SpikeOut, AddrOut, Membrane, DroppedCount});
            else passed++;
        end
    endtask

    task automatic test_leak();
        obs_t e, g;
        int seq [5] = '{40, 35, 31, 28, 25};
        for (int k = 0; k < 14; k++) begin
            drive_cycle(1'b1, k == 0, (k == 0) ? 40 : 0);
            e = exp_q.pop_front(); g = sample();
            checks++;
            if (g !== e) $display("FAIL leak cyc%0d got=%h exp=%h", k, g, e);
            else passed++;
            if (k < 5) begin
                checks++;
                if (Membrane !== 16'(seq[k]) || SpikeOut !== 1'b0)
                    $display("FAIL leak_seq cyc%0d got=%0d exp=%0d", k, Membrane, seq[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_fire_refractory();
        obs_t e, g;
        int refr_cycles = 0;
        drive_cycle(1'b1, 1'b1, 120);
        e = exp_q.pop_front(); g = sample();
        checks++;
        if (g !== e) $display("FAIL fire got=%h exp=%h", g, e);
        else passed++;
        checks++;
        if (SpikeOut !== 1'b1 || AddrOut !== 8'h05 || Membrane !== 16'sd0 || Refractory !== 1'b1)
            $display("FAIL fire_const got=%b/%h/%0d/%b exp=1/05/0/1", SpikeOut, AddrOut, Membrane, Refractory);
        else passed++;
        refr_cycles = 1;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, k < 3, 90);
            e = exp_q.pop_front(); g = sample();
            checks++;
            if (g !== e) $display("FAIL refract cyc%0d got=%h exp=%h", k, g, e);
            else passed++;
            if (Refractory === 1'b1) refr_cycles++;
        end
        checks++;
        if (refr_cycles !== 4 || DroppedCount !== 8'd3)
            $display("FAIL refract_len got=%0d/%0d exp=4/3", refr_cycles, DroppedCount);
        else passed++;
        drive_cycle(1'b1, 1'b1, 40);
        e = exp_q.pop_front(); g = sample();
        checks++;
        if (g !== e || Membrane !== 16'sd40 || Refractory !== 1'b0)
            $display("FAIL first_integrate got=%h exp=%h", g, e);
        else passed++;
    endtask

    task automatic test_saturation();
        obs_t e, g;
        for (int k = 0; k < 8; k++) drive_cycle(1'b1, 1'b0, 0);
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        drive_cycle(1'b1, 1'b1, 32'h0001_0000);
        e = exp_q.pop_front(); g = sample();
        checks++;
        if (g !== e || SpikeOut !== 1'b1 || Membrane !== 16'sd0)
            $display("FAIL saturate got=%h exp=%h", g, e);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'b0, 0);
            e = exp_q.pop_front(); g = sample();
            checks++;
            if (g !== e) $display("FAIL sat_refract cyc%0d got=%h exp=%h", k, g, e);
            else passed++;
        end
        drive_cycle(1'b1, 1'b1, 30);
        e = exp_q.pop_front(); g = sample();
        checks++;
        if (g !== e || Membrane !== 16'sd30) $display("FAIL floor_pre got=%0d exp=30", Membrane);
        else passed++;
        drive_cycle(1'b1, 1'b1, -50);
        e = exp_q.pop_front(); g = sample();
        checks++;
        if (g !== e || Membrane !== 16'sd0) $display("FAIL floor got=%0d exp=0", Membrane);
        else passed++;
    endtask

    task automatic test_reset_mid_refract();
        obs_t e, g;
        drive_cycle(1'b1, 1'b1, 120);
        drive_cycle(1'b1, 1'b0, 0);
        drive_cycle(1'b0, 1'b1, 120);
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        e = exp_q.pop_front(); g = sample();
        checks++;
        if (g !== e || Refractory !== 1'b0 || DroppedCount !== 8'd0)
            $display("FAIL reset_mid got=%h exp=%h", g, e);
        else passed++;
        drive_cycle(1'b1, 1'b1, 120);
        e = exp_q.pop_front(); g = sample();
        checks++;
        if (g !== e || SpikeOut !== 1'b1 || AddrOut !== 8'h05)
            $display("FAIL refire got=%h exp=%h", g, e);
        else passed++;
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b0, 0);
        while (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        int errs = 0;
        for (int k = 0; k < 60; k++)
            drive_cycle(1'b1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 400)) - 150);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            errs = errs;
        end
        // Re-run with per-cycle checking so every random cycle is compared.
        for (int k = 0; k < 60; k++) begin
            drive_cycle(1'b1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 400)) - 150);
            e = exp_q.pop_front(); g = sample();
            checks++;
            if (g !== e) $display("FAIL random cyc%0d got=%h exp=%h", k, g, e);
            else passed++;
        end
    endtask

`ifdef LIF_SPIKE_COUNT_EN
    task automatic test_spike_count();
        drive_cycle(1'b0, 1'b0, 0);
        for (int n = 0; n < 5; n++) begin
            drive_cycle(1'b1, 1'b1, 120);
            for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b0, 0);
        end
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if (SpikeCount !== 16'd5 || SpikeCount !== 16'(m_cnt))
            $display("FAIL spike_count got=%0d exp=5", SpikeCount);
        else passed++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; CurrentValid = 1'b0; CurrentIn = 32'd0;
        @(negedge Clk);
        test_reset();
        test_leak();
        test_fire_refractory();
        test_saturation();
        test_reset_mid_refract();
        test_back_to_back();
`ifdef LIF_SPIKE_COUNT_EN
        test_spike_count();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lif_integrator.md
# lif_integrator

Postsynaptic leaky integrate-and-fire stage that sits on the receiving end of `synapse`. It consumes the synapse's 32-bit current words, leaks and integrates them into a saturating membrane potential, and fires a one-cycle spike with its own 8-bit address. Its spike/address pair has the same form as the presynaptic `neuron` output, so the spike can drive the next synapse layer.

## Interface
- `THRESHOLD`, default 100: firing threshold, signed, compared against membrane `V` (`V_WIDTH` bits).
- `LEAK_SHIFT`, default 3: per-cycle leak is `V >>> LEAK_SHIFT`; 1..7.
- `REFRACTORY_CYCLES`, default 4: cycles spent ignoring input after a spike; 0..255.
- `NEURON_ADDR`, default 8'h01: address emitted with each spike.
- `V_WIDTH`, default 16: membrane width, signed.
- `Clk` input 1: sole clock, rising edge.
- `Reset` input 1: synchronous, active-low.
- `CurrentIn` input 32: signed current word from the synapse.
- `CurrentValid` input 1: `CurrentIn` is meaningful this cycle.
- `SpikeOut` output 1: one-cycle registered spike pulse.
- `AddrOut` output 8: `NEURON_ADDR` while `SpikeOut`=1, else 8'h00.
- `Membrane` output `V_WIDTH`: current registered `V`.
- `Refractory` output 1: high while in `REFRACT`.
- `DroppedCount` output 8: saturating count of valid inputs discarded during refractory.

## Operation
- States:
  - `INTEGRATE` is the reset state.
  - `REFRACT` holds a down-counter `rc`.
- `INTEGRATE`, each cycle:
  - `I = CurrentValid ? sat(CurrentIn) : 0`. `sat` clamps to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1].
  - `Vn = V - (V >>> LEAK_SHIFT) + I`, computed at `V_WIDTH+2` bits.
  - `Vn` is floored at 0 and clamped at 2^(V_WIDTH-1)-1.
- Fire when `Vn >= THRESHOLD`. On that edge:
  - `SpikeOut`=1, `AddrOut`=`NEURON_ADDR`, `V`=0.
  - If `REFRACTORY_CYCLES`>0: go to `REFRACT` with `rc`=`REFRACTORY_CYCLES`.
  - Else stay in `INTEGRATE`.
- No fire: `V`=`Vn`, `SpikeOut`=0, `AddrOut`=0.
- `REFRACT`:
  - `V` is held at 0.
  - No leak and no integration.
  - Any `CurrentValid`=1 increments `DroppedCount`, saturating at 255.
  - `rc` decrements each cycle. When `rc`=1, the next state is `INTEGRATE`.
- Leak below 2^LEAK_SHIFT evaluates to 0. Small `V` therefore persists; this is intended.
- Spikes never occur on consecutive cycles unless `REFRACTORY_CYCLES`=0 and the input sustains the threshold.

## Timing
- Reset (`Reset`=0 at an edge) clears all state:
  - `V`=0, `SpikeOut`=0, `AddrOut`=0, `Refractory`=0, `DroppedCount`=0.
  - `rc`=0, state `INTEGRATE`.
  - Reset takes priority over everything, including mid-refractory and a same-cycle fire.
- Latency: a valid input sampled at edge N updates `Membrane` at edge N. A resulting spike is visible on `SpikeOut` in cycle N→N+1 (one cycle after input is presented).
- `SpikeOut` is high for exactly one cycle per fire.
- `Refractory` rises with `SpikeOut` and stays high for `REFRACTORY_CYCLES` cycles.
- Input presented on the last `REFRACT` cycle is dropped. Input on the first `INTEGRATE` cycle is accepted.
- `CurrentValid` has no backpressure: it is a pure strobe and is accepted or dropped in the same cycle.

## Configuration
- Macro `LIF_SPIKE_COUNT_EN`.
- Defined:
  - Adds output port `SpikeCount` [15:0], reset to 0.
  - Increments on every fire and wraps at 16'hFFFF→0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use `THRESHOLD`=100, `LEAK_SHIFT`=3, `REFRACTORY_CYCLES`=4, `NEURON_ADDR`=8'h05.
- **Reset:** `Reset`=0 for 3 cycles with `CurrentValid`=1, `CurrentIn`=500.
  - Expect `SpikeOut`=0, `AddrOut`=0, `Membrane`=0, `DroppedCount`=0 throughout.
- **Leak:** one pulse `CurrentIn`=40, then idle.
  - Expect `Membrane` 40, 35, 31, 28, 25, … and no spike.
- **Fire and refractory:** `CurrentIn`=120 for one cycle.
  - Next cycle: `SpikeOut`=1, `AddrOut`=8'h05, `Membrane`=0.
  - `Refractory`=1 for 4 cycles.
  - 3 valid inputs during `REFRACT` give `DroppedCount`=3 and `Membrane` stays 0.
- **Saturation:** `CurrentIn`=32'h0001_0000 → clamped to 32767 → immediate fire.
  - **Negative floor:** from `V`=30, `CurrentIn`=-50 gives `Membrane`=0.
- **Reset mid-refractory:** assert `Reset`=0 on the 2nd `REFRACT` cycle.
  - Expect `Refractory`=0 and state `INTEGRATE`.
  - `CurrentIn`=120 after release fires again one cycle later.
- **`LIF_SPIKE_COUNT_EN` defined:** 5 fires give `SpikeCount`=5.
